// File: rtl/geo_ram_port.sv
// -----------------------------------------------------------------------------
// geo_ram_port
//
// Downstream memory port of the geometry processor. Pixel-channel requests
// (write, read/modify/write read, COPY read) are queued in arrival order and
// issued one at a time to the shared graphics-RAM arbiter. Read data coming
// back from the arbiter is steered to the channel that issued the read.
// ram_mux_busy throttles the pixel writer before the queue can overflow.
//
// Optional feature (compile-time macro GEO_RAM_PORT_STATS_EN):
//   adds stat_clr input and stat_wr / stat_rd / stat_rdC saturating counters
//   of granted writes, RMW reads and COPY reads.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   wr_ena              write request from the pixel writer
//   rd_req              read request, read/modify/write channel
//   rd_req_C            read request, COPY channel
//   ram_addr[19:0]      request address
//   ram_wr_data[15:0]   write data
//   ram_mux_busy        queue nearly full, pixel writer must stall
//   rd_data_in[15:0]    read data, RMW channel (held until next strobe)
//   rd_data_rdy         one-cycle strobe, RMW data valid
//   rd_data_in_C[15:0]  read data, COPY channel (held until next strobe)
//   rd_data_rdy_C       one-cycle strobe, COPY data valid
//   mem_req/mem_we/mem_addr/mem_wdata   registered request to the arbiter
//   mem_grant           arbiter accepts the presented request this cycle
//   mem_rdata, mem_rvalid  read return, READ_LATENCY cycles after a read grant
//   proto_err           sticky: dropped request or unexpected read data
// -----------------------------------------------------------------------------
module geo_ram_port #(
    parameter int DEPTH        = 16,
    parameter int MARGIN       = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ena,
    input  logic        rd_req,
    input  logic        rd_req_C,
    input  logic [19:0] ram_addr,
    input  logic [15:0] ram_wr_data,
    output logic        ram_mux_busy,
    output logic [15:0] rd_data_in,
    output logic        rd_data_rdy,
    output logic [15:0] rd_data_in_C,
    output logic        rd_data_rdy_C,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_grant,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
`ifdef GEO_RAM_PORT_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_rdC,
`endif
    output logic        proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        KIND_WR   = 2'd0,
        KIND_RMW  = 2'd1,
        KIND_COPY = 2'd2
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [19:0] addr;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_LOAD    = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Request selection: one enqueue per cycle, COPY > RMW > write
    // ------------------------------------------------------------------
    entry_t     req_entry;
    logic       req_valid;
    logic       req_multi;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        req_entry.kind = KIND_WR;
        req_entry.addr = ram_addr;
        req_entry.data = ram_wr_data;
        if (rd_req_C) begin
            req_entry.kind = KIND_COPY;
        end else if (rd_req) begin
            req_entry.kind = KIND_RMW;
        end
    end

    assign req_valid = wr_ena | rd_req | rd_req_C;
    assign req_multi = (rd_req_C & rd_req) | (rd_req_C & wr_ena) | (rd_req & wr_ena);

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    entry_t             queue_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q;
    state_e             state_q;
    entry_t             head;
    logic               full;
    logic               push;
    logic               pop;

    assign head    = queue_mem[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push    = req_valid && !full;
    // Only the PRESENT state drives mem_req, so a grant elsewhere is ignored.
    assign pop     = (state_q == S_PRESENT) && mem_grant;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // NOTE: the storage array carries no reset; the pointers and count alone
    // say which entries are live, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr_q] <= req_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_d;
            // Evaluated on next-state count so the stall is seen one cycle
            // after the push that reaches the threshold.
            busy_q   <= (count_d >= CNT_W'(DEPTH - MARGIN));
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered arbiter outputs
    // ------------------------------------------------------------------
    logic        mem_req_q;
    logic        mem_we_q;
    logic [19:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        mem_copy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_copy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= S_PRESENT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (head.kind == KIND_WR);
                        mem_copy_q  <= (head.kind == KIND_COPY);
                        mem_addr_q  <= head.addr;
                        mem_wdata_q <= head.data;
                    end
                end
                S_PRESENT: begin
                    if (mem_grant) begin
                        mem_req_q <= 1'b0;
                        state_q   <= (count_d == '0) ? S_IDLE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    // rd_ptr_q already points at the new head here.
                    state_q     <= S_PRESENT;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= (head.kind == KIND_WR);
                    mem_copy_q  <= (head.kind == KIND_COPY);
                    mem_addr_q  <= head.addr;
                    mem_wdata_q <= head.data;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read tag pipeline: one slot per cycle, bubbles for writes / no grant,
    // so the output slot lines up with mem_rvalid of the matching read.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [READ_LATENCY-1:0] tag_copy_q;
    logic                    rd_accept;
    logic                    tag_hit;
    logic                    tag_stray;

    assign rd_accept = pop && !mem_we_q;
    assign tag_hit   = mem_rvalid && tag_vld_q[READ_LATENCY-1];
    assign tag_stray = mem_rvalid && !tag_vld_q[READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q  <= '0;
            tag_copy_q <= '0;
        end else begin
            tag_vld_q[0]  <= rd_accept;
            tag_copy_q[0] <= mem_copy_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_copy_q[i] <= tag_copy_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return steering and protocol error flag
    // ------------------------------------------------------------------
    logic [15:0] rd_data_q, rd_data_c_q;
    logic        rd_rdy_q, rd_rdy_c_q;
    logic        proto_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q   <= '0;
            rd_data_c_q <= '0;
            rd_rdy_q    <= 1'b0;
            rd_rdy_c_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rd_rdy_q   <= tag_hit && !tag_copy_q[READ_LATENCY-1];
            rd_rdy_c_q <= tag_hit &&  tag_copy_q[READ_LATENCY-1];
            if (tag_hit) begin
                if (tag_copy_q[READ_LATENCY-1]) begin
                    rd_data_c_q <= mem_rdata;
                end else begin
                    rd_data_q <= mem_rdata;
                end
            end
            if ((req_valid && (req_multi || full)) || tag_stray) begin
                proto_err_q <= 1'b1;
            end
        end
    end

`ifdef GEO_RAM_PORT_STATS_EN
    // ------------------------------------------------------------------
    // Granted-request statistics, saturating at all-ones
    // ------------------------------------------------------------------
    logic [15:0] stat_wr_q, stat_rd_q, stat_rdc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_rdc_q <= '0;
        end else if (stat_clr) begin
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_rdc_q <= '0;
        end else if (pop) begin
            if (mem_we_q) begin
                if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
            end else if (mem_copy_q) begin
                if (stat_rdc_q != 16'hFFFF) stat_rdc_q <= stat_rdc_q + 16'd1;
            end else begin
                if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_wr  = stat_wr_q;
    assign stat_rd  = stat_rd_q;
    assign stat_rdC = stat_rdc_q;
`endif

    assign ram_mux_busy  = busy_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign rd_data_in    = rd_data_q;
    assign rd_data_in_C  = rd_data_c_q;
    assign rd_data_rdy   = rd_rdy_q;
    assign rd_data_rdy_C = rd_rdy_c_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_geo_ram_port.sv
// -----------------------------------------------------------------------------
// tb_geo_ram_port
//
// Self-checking bench for geo_ram_port. A transaction-level reference model
// (a queue of pending requests plus a table of expected read returns) is
// updated from the stimulus; the bench also plays the arbiter, answering
// every granted read with data exactly READ_LATENCY cycles later.
// Outputs are sampled on the falling edge; inputs change right after.
// -----------------------------------------------------------------------------
module tb_geo_ram_port;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_ena = 1'b0, rd_req = 1'b0, rd_req_C = 1'b0;
    logic [19:0] ram_addr = '0;
    logic [15:0] ram_wr_data = '0;
    logic        ram_mux_busy;
    logic [15:0] rd_data_in, rd_data_in_C;
    logic        rd_data_rdy, rd_data_rdy_C;
    logic        mem_req, mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_grant = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        proto_err;
`ifdef GEO_RAM_PORT_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_wr, stat_rd, stat_rdC;
`endif

    always #5 clk = ~clk;

    geo_ram_port #(.DEPTH(DEPTH), .MARGIN(MARGIN), .READ_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ena       (wr_ena),
        .rd_req       (rd_req),
        .rd_req_C     (rd_req_C),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_mux_busy (ram_mux_busy),
        .rd_data_in   (rd_data_in),
        .rd_data_rdy  (rd_data_rdy),
        .rd_data_in_C (rd_data_in_C),
        .rd_data_rdy_C(rd_data_rdy_C),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_grant    (mem_grant),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
`ifdef GEO_RAM_PORT_STATS_EN
        .stat_clr     (stat_clr),
        .stat_wr      (stat_wr),
        .stat_rd      (stat_rd),
        .stat_rdC     (stat_rdC),
`endif
        .proto_err    (proto_err)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        int          kind;   // 0 write, 1 RMW read, 2 COPY read
        logic [19:0] addr;
        logic [15:0] data;
    } req_t;

    req_t        model_q[$];
    logic [15:0] forced_rdata[$];

    // Arbiter read-return slots and expected strobe slots, indexed by cycle.
    logic        rv_v [8];
    logic        rv_c [8];
    logic [15:0] rv_d [8];
    int          rv_epoch [8];
    logic        es_v [8];
    logic        es_c [8];
    logic [15:0] es_d [8];

    int          cyc = 0;
    int          epoch = 0;
    int          grant_mode = 0;   // 0 never, 1 always, 2 random, 3 one grant
    int          n_granted = 0;
    int          idle_run = 0;
    logic        prev_granted = 1'b0;
    logic        exp_proto = 1'b0;
    logic [15:0] exp_rd = '0, exp_rdc = '0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},    32'(ram_mux_busy),  32'h0);
        check({pfx, "_req"},     32'(mem_req),       32'h0);
        check({pfx, "_we"},      32'(mem_we),        32'h0);
        check({pfx, "_addr"},    32'(mem_addr),      32'h0);
        check({pfx, "_wdata"},   32'(mem_wdata),     32'h0);
        check({pfx, "_rdy"},     32'(rd_data_rdy),   32'h0);
        check({pfx, "_rdy_c"},   32'(rd_data_rdy_C), 32'h0);
        check({pfx, "_rd"},      32'(rd_data_in),    32'h0);
        check({pfx, "_rd_c"},    32'(rd_data_in_C),  32'h0);
        check({pfx, "_proto"},   32'(proto_err),     32'h0);
`ifdef GEO_RAM_PORT_STATS_EN
        check({pfx, "_stat_wr"}, 32'(stat_wr),       32'h0);
        check({pfx, "_stat_rd"}, 32'(stat_rd),       32'h0);
        check({pfx, "_stat_rdC"},32'(stat_rdC),      32'h0);
`endif
    endtask

    // One clock cycle: check outputs against the model, play the arbiter,
    // then present this cycle's pixel-channel request.
    task automatic tick(input logic w, input logic r, input logic c,
                        input logic [19:0] a, input logic [15:0] d);
        int s, sn, sz0;
        @(negedge clk);
        s  = cyc % 8;
        sn = (cyc + 1) % 8;

        if (es_v[s]) begin
            if (es_c[s]) exp_rdc = es_d[s];
            else         exp_rd  = es_d[s];
        end
        check("rd_data_rdy",   32'(rd_data_rdy),   32'(es_v[s] && !es_c[s]));
        check("rd_data_rdy_C", 32'(rd_data_rdy_C), 32'(es_v[s] &&  es_c[s]));
        check("rd_data_in",    32'(rd_data_in),    32'(exp_rd));
        check("rd_data_in_C",  32'(rd_data_in_C),  32'(exp_rdc));
        es_v[s] = 1'b0;

        check("ram_mux_busy", 32'(ram_mux_busy), 32'(model_q.size() >= DEPTH - MARGIN));
        check("proto_err",    32'(proto_err),    32'(exp_proto));
        if (prev_granted) check("gap_after_grant", 32'(mem_req), 32'h0);

        if (mem_req) begin
            check("req_nonempty", 32'(model_q.size() != 0), 32'h1);
            if (model_q.size() != 0) begin
                check("mem_we",    32'(mem_we),    32'(model_q[0].kind == 0));
                check("mem_addr",  32'(mem_addr),  32'(model_q[0].addr));
                check("mem_wdata", 32'(mem_wdata), 32'(model_q[0].data));
            end
        end
        if (model_q.size() != 0 && !mem_req) idle_run++;
        else                                 idle_run = 0;
        check("issue_gap", 32'(idle_run > 1), 32'h0);

        // Arbiter read return scheduled READ_LATENCY cycles after the grant.
        if (rv_v[s]) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_d[s];
            if (rv_epoch[s] == epoch) begin
                es_v[sn] = 1'b1;
                es_c[sn] = rv_c[s];
                es_d[sn] = rv_d[s];
            end else begin
                exp_proto = 1'b1;   // read issued before the last reset
            end
            rv_v[s] = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end

        case (grant_mode)
            1:       mem_grant = 1'b1;
            2:       mem_grant = 1'($urandom_range(0, 1));
            3:       mem_grant = 1'b1;
            default: mem_grant = 1'b0;
        endcase
        if (grant_mode == 3 && mem_req) grant_mode = 0;

        sz0 = model_q.size();
        prev_granted = mem_req && mem_grant;
        if (prev_granted && model_q.size() != 0) begin
            n_granted++;
            if (model_q[0].kind != 0) begin
                rv_v[(cyc + LAT) % 8]     = 1'b1;
                rv_c[(cyc + LAT) % 8]     = (model_q[0].kind == 2);
                rv_d[(cyc + LAT) % 8]     = (forced_rdata.size() != 0) ?
                                            forced_rdata.pop_front() : 16'($urandom);
                rv_epoch[(cyc + LAT) % 8] = epoch;
            end
            void'(model_q.pop_front());
        end

        wr_ena      = w;
        rd_req      = r;
        rd_req_C    = c;
        ram_addr    = a;
        ram_wr_data = d;
        if (w || r || c) begin
            if (int'(w) + int'(r) + int'(c) > 1) exp_proto = 1'b1;
            if (sz0 == DEPTH) begin
                exp_proto = 1'b1;
            end else begin
                model_q.push_back('{kind: (c ? 2 : (r ? 1 : 0)), addr: a, data: d});
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    endtask

    task automatic drain();
        grant_mode = 1;
        for (int i = 0; i < 200 && model_q.size() != 0; i++) idle(1);
        check("drain_empty", 32'(model_q.size()), 32'h0);
        idle(6);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #1;
        reset      = 1'b0;
        wr_ena     = 1'b0;
        rd_req     = 1'b0;
        rd_req_C   = 1'b0;
        mem_grant  = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check_reset_outputs("rst");
        model_q.delete();
        for (int i = 0; i < 8; i++) es_v[i] = 1'b0;
        exp_proto    = 1'b0;
        exp_rd       = '0;
        exp_rdc      = '0;
        prev_granted = 1'b0;
        idle_run     = 0;
        epoch++;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_r, cnt_c;
        logic w, r, c;
        int sel;

        for (int i = 0; i < 8; i++) begin
            rv_v[i] = 1'b0; rv_c[i] = 1'b0; rv_d[i] = '0; rv_epoch[i] = 0;
            es_v[i] = 1'b0; es_c[i] = 1'b0; es_d[i] = '0;
        end

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        #2 reset = 1'b1;

        // Single write with grant tied high: presented 2 cycles after request.
        grant_mode = 1;
        tick(1'b1, 1'b0, 1'b0, 20'h01234, 16'hBEEF);
        idle(1);
        check("t1_req_early", 32'(mem_req), 32'h0);
        idle(1);
        check("t1_req",   32'(mem_req),   32'h1);
        check("t1_we",    32'(mem_we),    32'h1);
        check("t1_addr",  32'(mem_addr),  32'h01234);
        check("t1_wdata", 32'(mem_wdata), 32'hBEEF);
        check("t1_rdy",   32'(rd_data_rdy | rd_data_rdy_C), 32'h0);
        idle(4);

        // RMW read then COPY read, each returned to its own channel.
        forced_rdata.push_back(16'h1111);
        forced_rdata.push_back(16'h2222);
        cnt_r = 0;
        cnt_c = 0;
        tick(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 20'h00020, 16'h0);
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (rd_data_rdy)   cnt_r++;
            if (rd_data_rdy_C) cnt_c++;
        end
        check("t2_rdy_count",   32'(cnt_r), 32'd1);
        check("t2_rdy_c_count", 32'(cnt_c), 32'd1);
        check("t2_rd_data",     32'(rd_data_in),   32'h1111);
        check("t2_rd_data_c",   32'(rd_data_in_C), 32'h2222);

        // Busy threshold: 12 queued writes, then one grant.
        grant_mode = 0;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 20'(32'h100 + i), 16'(32'hA000 + i));
        idle(1);
        check("t3_busy_set", 32'(ram_mux_busy), 32'h1);
        grant_mode = 3;
        idle(2);
        check("t3_busy_clear", 32'(ram_mux_busy), 32'h0);
        drain();

        // Overflow: 17 writes into a stalled queue, 16 issued in order.
        do_reset();
        grant_mode = 0;
        for (int i = 0; i < 17; i++) tick(1'b1, 1'b0, 1'b0, 20'($urandom), 16'($urandom));
        idle(1);
        check("t4_proto", 32'(proto_err),    32'h1);
        check("t4_busy",  32'(ram_mux_busy), 32'h1);
        n_granted = 0;
        drain();
        check("t4_issued", 32'(n_granted), 32'd16);

        // Simultaneous read and write: only the read is queued.
        do_reset();
        n_granted = 0;
        tick(1'b1, 1'b1, 1'b0, 20'h00555, 16'h5A5A);
        drain();
        check("t5_proto",  32'(proto_err), 32'h1);
        check("t5_issued", 32'(n_granted), 32'd1);

        // Randomized traffic; the pixel writer honours ram_mux_busy.
        do_reset();
        grant_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            w = 1'b0; r = 1'b0; c = 1'b0;
            sel = $urandom_range(0, 15);
            if (!ram_mux_busy) begin
                if (sel < 4)       w = 1'b1;
                else if (sel < 7)  r = 1'b1;
                else if (sel < 9)  c = 1'b1;
                else if (sel == 9) begin w = 1'b1; c = 1'b1; end
                else if (sel == 10) begin w = 1'b1; r = 1'b1; end
            end
            tick(w, r, c, 20'($urandom), 16'($urandom));
        end
        drain();

        // Reset with a read in flight and 5 entries queued.
        do_reset();
        grant_mode = 0;
        tick(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 20'h00020, 16'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 20'(32'h200 + i), 16'(32'hC000 + i));
        idle(1);
        grant_mode = 1;
        idle(4);
        do_reset();
        cnt_r = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (rd_data_rdy || rd_data_rdy_C) cnt_r++;
        end
        check("t6_no_strobe",  32'(cnt_r),     32'd0);
        check("t6_stray_flag", 32'(proto_err), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
